mem_read_master: RTL and testbench



---
 rtl/mem_read_master_pkg.sv | 28 ++
 rtl/mem_read_master_wait_counter.sv | 32 +++
 rtl/mem_read_master.sv | 116 +++++++++++
 tb/tb_mem_read_master.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_read_master_pkg.sv
// Shared widths, state encoding and helpers for the sEP8 memory read master.
// Imported by the top-level FSM and its wait counter.
package mem_read_master_pkg;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 8;
  localparam int NB_W   = 2;
  localparam int WORD_W = 3 * DATA_W;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_RELEASE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Counter width able to hold WAIT_CYCLES-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // A byte count of zero is a one-byte read.
  function automatic logic [NB_W-1:0] eff_nbytes(input logic [NB_W-1:0] n);
    return (n == '0) ? NB_W'(1) : n;
  endfunction

endpackage

// File: rtl/mem_read_master_wait_counter.sv
// Loadable down-counter timing the strobe window; o_tc is high on the last
// strobe cycle, when the bus data is captured.
module mem_read_master_wait_counter
  import mem_read_master_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic i_load,
  input  logic i_en,
  output logic o_tc
);

  localparam int CNT_W = cnt_width(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= LOAD_VAL;
    end else if (i_en && !o_tc) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_tc = (r_count == '0);

endmodule

// File: rtl/mem_read_master.sv
// sEP8 bus initiator: reads 1..3 consecutive bytes with a fixed strobe wait
// and assembles them little-endian into data_out.
module mem_read_master
  import mem_read_master_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [NB_W-1:0]   nbytes,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] data_out,
  output logic [ADDR_W-1:0] a23_a0,
  output logic              s_,
  output logic              mr_,
  input  logic [DATA_W-1:0] d7_d0,
  output state_t            o_dbg_state
);

  // Request handshake: req is a strobe sampled only in IDLE; there is no ready.
  // busy high means a req is dropped, and done pulses once per accepted req.

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_addr;
  logic [NB_W-1:0]   r_nbytes;
  logic [NB_W-1:0]   r_idx;
  logic [WORD_W-1:0] r_data;
  logic              r_strobe_n;
  logic              r_busy;
  logic              r_done;
  logic              w_wc_tc;
  logic              w_more;

  mem_read_master_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_counter (
    .clock  (clock),
    .reset  (reset),
    .i_load (r_state == ST_SETUP),
    .i_en   (r_state == ST_STROBE),
    .o_tc   (w_wc_tc)
  );

  assign w_more = ({1'b0, r_idx} + 3'd1) < {1'b0, r_nbytes};

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (req) w_next_state = ST_SETUP;
      ST_SETUP:   w_next_state = ST_STROBE;
      ST_STROBE:  if (w_wc_tc) w_next_state = ST_RELEASE;
      ST_RELEASE: w_next_state = w_more ? ST_SETUP : ST_DONE;
      ST_DONE:    w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // Bus and status flags are registered from the next state so s_/mr_ are
  // glitch-free and only fall once the address has been stable for SETUP.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_strobe_n <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_addr     <= '0;
      r_nbytes   <= '0;
      r_idx      <= '0;
      r_data     <= '0;
    end else begin
      r_state    <= w_next_state;
      r_strobe_n <= (w_next_state != ST_STROBE);
      r_busy     <= (w_next_state != ST_IDLE);
      r_done     <= (w_next_state == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (req) begin
            r_addr   <= addr_in;
            r_nbytes <= eff_nbytes(nbytes);
            r_idx    <= '0;
            r_data   <= '0;
          end
        end
        ST_STROBE: begin
          if (w_wc_tc) begin
            case (r_idx)
              2'd0:    r_data[7:0]   <= d7_d0;
              2'd1:    r_data[15:8]  <= d7_d0;
              default: r_data[23:16] <= d7_d0;
            endcase
          end
        end
        ST_RELEASE: begin
          if (w_more) begin
            r_idx  <= r_idx + NB_W'(1);
            r_addr <= r_addr + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign a23_a0      = r_addr;
  assign s_          = r_strobe_n;
  assign mr_         = r_strobe_n;
  assign busy        = r_busy;
  assign done        = r_done;
  assign data_out    = r_data;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_read_master.sv
// Directed bench for mem_read_master with a small ROM responder (2-unit read
// delay) and a bus monitor that records every strobe window.
module tb_mem_read_master;
  import mem_read_master_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        req;
  logic [23:0] addr_in;
  logic [1:0]  nbytes;
  logic        busy;
  logic        done;
  logic [23:0] data_out;
  logic [23:0] a23_a0;
  logic        s_;
  logic        mr_;
  wire  [7:0]  d7_d0;
  state_t      dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [7:0] OPC_MOV_AH = 8'hB4;

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  mem_read_master #(.WAIT_CYCLES(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .addr_in     (addr_in),
    .nbytes      (nbytes),
    .busy        (busy),
    .done        (done),
    .data_out    (data_out),
    .a23_a0      (a23_a0),
    .s_          (s_),
    .mr_         (mr_),
    .d7_d0       (d7_d0),
    .o_dbg_state (dbg_state)
  );

  // ---------------- ROM responder ----------------
  logic       rom_hit;
  logic [7:0] rom_q;
  always_comb begin
    rom_hit = (a23_a0[23:4] == 20'hFF000);
    case (a23_a0[3:0])
      4'h1:    rom_q = OPC_MOV_AH;
      4'h2:    rom_q = 8'h41;
      4'h4:    rom_q = 8'h11;
      4'h5:    rom_q = 8'h22;
      4'h9:    rom_q = 8'h03;
      4'hA:    rom_q = 8'h00;
      4'hB:    rom_q = 8'hFF;
      default: rom_q = 8'h00;
    endcase
  end
  assign #2 d7_d0 = (!s_ && !mr_ && rom_hit) ? rom_q : 8'hzz;

  // ---------------- bus monitor ----------------
  // Each closed strobe window is logged as {length[7:0], address[23:0]}.
  logic [31:0] obs_q[$];
  logic [31:0] exp_q[$];
  logic        in_win = 1'b0;
  logic [23:0] win_addr;
  logic [7:0]  win_len;
  int          bus_viol = 0;

  always @(negedge clock) begin
    if (s_ !== mr_) bus_viol++;
    if (s_ === 1'b0) begin
      if (!in_win) begin
        in_win   = 1'b1;
        win_addr = a23_a0;
        win_len  = 8'd1;
      end else begin
        win_len++;
        if (a23_a0 !== win_addr) bus_viol++;
      end
    end else if (in_win) begin
      in_win = 1'b0;
      obs_q.push_back({win_len, win_addr});
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_windows(input string tag);
    check({tag, "_win_count"}, 48'(obs_q.size()), 48'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0)
      check({tag, "_win"}, 48'(obs_q.pop_front()), 48'(exp_q.pop_front()));
    exp_q.delete();
    obs_q.delete();
  endtask

  // ---------------- driver ----------------
  // Issues one request and measures the cycle of done, counting the cycle
  // after the accepting edge as cycle 1. With spam set, extra req pulses are
  // raised while busy; they must be ignored.
  task automatic run_xfer(input string tag, input logic [23:0] a, input logic [1:0] n,
                          input int exp_lat, input bit chk_data,
                          input logic [23:0] exp_data, input bit spam);
    int lat;
    @(negedge clock);
    req = 1'b1; addr_in = a; nbytes = n;
    @(posedge clock); #1;
    req = 1'b0;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 1) check({tag, "_busy_c1"}, 48'(busy), 48'd1);
      if (spam && (c == 3 || c == 7)) begin
        req = 1'b1; addr_in = 24'hFF0009; nbytes = 2'd3;
      end else begin
        req = 1'b0;
      end
      if (done === 1'b1) begin
        lat = c;
        break;
      end
      @(posedge clock); #1;
    end
    req = 1'b0;
    check({tag, "_done_cycle"}, 48'(lat), 48'(exp_lat));
    check({tag, "_busy_at_done"}, 48'(busy), 48'd1);
    if (chk_data) check({tag, "_data"}, 48'(data_out), 48'(exp_data));
    @(posedge clock); #1;
    check({tag, "_after_done"}, {46'd0, busy, done}, 48'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1; req = 1'b1; addr_in = 24'hFF0001; nbytes = 2'd1;

    repeat (2) begin
      @(posedge clock); #1;
      check("reset_outputs", {20'd0, s_, mr_, busy, done, data_out}, {20'd0, 4'b1100, 24'h0});
    end
    check("reset_state", 48'(dbg_state), 48'(ST_IDLE));
    @(negedge clock);
    reset = 1'b0; req = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("idle_no_strobe", {46'd0, s_, mr_}, 48'b11);
    check("idle_no_windows", 48'(obs_q.size()), 48'd0);

    exp_q.push_back({8'd2, 24'hFF0001});
    run_xfer("one_byte", 24'hFF0001, 2'd1, 5, 1'b1, {16'h0000, OPC_MOV_AH}, 1'b0);
    check_windows("one_byte");
    repeat (3) @(posedge clock);
    #1;
    check("data_hold", 48'(data_out), {24'd0, 16'h0000, OPC_MOV_AH});

    exp_q.push_back({8'd2, 24'hFF0009});
    exp_q.push_back({8'd2, 24'hFF000A});
    exp_q.push_back({8'd2, 24'hFF000B});
    run_xfer("three_byte", 24'hFF0009, 2'd3, 13, 1'b1, 24'hFF0003, 1'b0);
    check_windows("three_byte");

    exp_q.push_back({8'd2, 24'hFFFFFF});
    exp_q.push_back({8'd2, 24'h000000});
    run_xfer("wrap", 24'hFFFFFF, 2'd2, 9, 1'b0, 24'h0, 1'b0);
    check_windows("wrap");

    exp_q.push_back({8'd2, 24'hFF0004});
    exp_q.push_back({8'd2, 24'hFF0005});
    run_xfer("req_while_busy", 24'hFF0004, 2'd2, 9, 1'b1, 24'h002211, 1'b1);
    check_windows("req_while_busy");

    // Reset lands in the second strobe window (cycle 6 after acceptance).
    @(negedge clock);
    req = 1'b1; addr_in = 24'hFF0009; nbytes = 2'd3;
    @(posedge clock); #1;
    req = 1'b0;
    repeat (5) begin
      @(posedge clock); #1;
    end
    check("mid_in_strobe", {46'd0, s_, mr_}, 48'b00);
    reset = 1'b1;
    @(posedge clock); #1;
    check("mid_reset_bus", {20'd0, s_, mr_, busy, done, data_out}, {20'd0, 4'b1100, 24'h0});
    check("mid_reset_state", 48'(dbg_state), 48'(ST_IDLE));
    @(negedge clock);
    reset = 1'b0;
    begin
      int done_seen = 0;
      repeat (20) begin
        @(posedge clock); #1;
        if (done === 1'b1) done_seen++;
      end
      check("mid_reset_no_done", 48'(done_seen), 48'd0);
    end
    exp_q.push_back({8'd2, 24'hFF0009});
    exp_q.push_back({8'd1, 24'hFF000A});
    check_windows("mid_reset");

    exp_q.push_back({8'd2, 24'hFF0002});
    run_xfer("nbytes_zero", 24'hFF0002, 2'd0, 5, 1'b1, 24'h000041, 1'b0);
    check_windows("nbytes_zero");

    // Back-to-back: the next request is driven in the cycle right after DONE.
    exp_q.push_back({8'd2, 24'hFF0001});
    run_xfer("back_to_back", 24'hFF0001, 2'd1, 5, 1'b1, {16'h0000, OPC_MOV_AH}, 1'b0);
    check_windows("back_to_back");

    check("bus_rules", 48'(bus_viol), 48'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
